// File: rtl/chord_loop_sequencer_pkg.sv
// Shared definitions for the chord looper controller: FSM encoding and tempo/step sizing helpers.
package chord_loop_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

   localparam int unsigned SEC_PER_MIN = 60;

   // Accumulator wrap value: one step is due every PERIOD/bpm clocks.
   function automatic longint unsigned calc_period(input longint unsigned clk_hz);
      return clk_hz * SEC_PER_MIN;
   endfunction

   function automatic int step_w(input int steps);
      return (steps > 1) ? $clog2(steps) : 1;
   endfunction

endpackage

// File: rtl/chord_loop_sequencer_tempo_gen.sv
// Phase accumulator tempo generator: adds bpm each enabled cycle and flags a step when it crosses PERIOD.
module chord_loop_sequencer_tempo_gen #(
   parameter int              BPM_W  = 8,
   parameter int              ACC_W  = 32,
   parameter longint unsigned PERIOD = 64'd600
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             en,
   input  logic             clr,
   input  logic [BPM_W-1:0] bpm,
   output logic             tick
);
   localparam logic [ACC_W:0] PERIOD_X = (ACC_W+1)'(PERIOD);

   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;
   logic [ACC_W:0]   sum;

   // One extra bit on the sum so acc+bpm can never overflow before the compare.
   always_comb begin
      sum   = {1'b0, acc_q} + {{(ACC_W+1-BPM_W){1'b0}}, bpm};
      tick  = 1'b0;
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         if (sum >= PERIOD_X) begin
            tick  = 1'b1;
            acc_d = ACC_W'(sum - PERIOD_X);
         end else begin
            acc_d = sum[ACC_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/chord_loop_sequencer.sv
// Looper timing and load controller: tempo steps, step/bar tracking, chord-key load
// arbitration and the one-shot tracking-LED load when looping starts.
module chord_loop_sequencer
   import chord_loop_sequencer_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int NUM_CHORDS = 4,
   parameter int STEPS      = 4,
   parameter int BPM_W      = 8,
   parameter int ACC_W      = 32
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     loop_en,
   input  logic [BPM_W-1:0]         bpm,
   input  logic [NUM_CHORDS-1:0]    key,
   output logic                     step_tick,
   output logic [step_w(STEPS)-1:0] step_idx,
   output logic                     bar_start,
   output logic [NUM_CHORDS-1:0]    chord_load,
   output logic                     track_load,
   output logic                     running
);
   localparam int              SW        = step_w(STEPS);
   localparam longint unsigned PERIOD    = calc_period(64'(CLK_HZ));
   localparam logic [SW-1:0]   LAST_STEP = SW'(STEPS - 1);

   state_e                state_q, state_d;
   logic [NUM_CHORDS-1:0] key_q;
   logic [NUM_CHORDS-1:0] key_edge;
   logic [NUM_CHORDS-1:0] pending_q, pending_d;
   logic [NUM_CHORDS-1:0] grant;
   logic [NUM_CHORDS-1:0] chord_load_q, chord_load_d;
   logic [SW-1:0]         step_idx_q, step_idx_d;
   logic                  bar_start_q, bar_start_d;
   logic                  step_tick_q;
   logic                  tick;
   logic                  tempo_en;
   logic                  tempo_clr;
   logic                  active;
   logic                  capture;

   assign active    = loop_en && (state_q == ST_RUN);
   assign capture   = loop_en && ((state_q == ST_ARM) || (state_q == ST_RUN));
   assign tempo_en  = (state_q == ST_RUN);
   assign tempo_clr = !loop_en || (state_q != ST_RUN);

   chord_loop_sequencer_tempo_gen #(
      .BPM_W  (BPM_W),
      .ACC_W  (ACC_W),
      .PERIOD (PERIOD)
   ) u_tempo_gen (
      .clk    (clk),
      .resetn (resetn),
      .en     (tempo_en),
      .clr    (tempo_clr),
      .bpm    (bpm),
      .tick   (tick)
   );

   // Dropping loop_en always wins, whatever state we are in.
   always_comb begin
      state_d    = state_q;
      track_load = 1'b0;
      running    = 1'b0;
      if (!loop_en) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_ARM;
            ST_ARM:  state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_IDLE;
         endcase
      end
      case (state_q)
         ST_ARM:  track_load = 1'b1;
         ST_RUN:  running    = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      step_idx_d  = step_idx_q;
      bar_start_d = 1'b0;
      if (!active) begin
         step_idx_d = '0;
      end else if (tick) begin
         step_idx_d  = (step_idx_q == LAST_STEP) ? '0 : step_idx_q + SW'(1);
         bar_start_d = (step_idx_q == LAST_STEP);
      end
   end

   // Lowest-index request wins; nothing is granted on a shift cycle so the
   // request simply stays pending one more cycle.
   always_comb begin
      key_edge     = key & ~key_q;
      grant        = pending_q & (~pending_q + NUM_CHORDS'(1));
      pending_d    = pending_q;
      chord_load_d = '0;
      if (!capture) begin
         pending_d = '0;
      end else if (active && !tick) begin
         chord_load_d = grant;
         pending_d    = (pending_q & ~grant) | key_edge;
      end else begin
         pending_d = pending_q | key_edge;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         key_q        <= '0;
         pending_q    <= '0;
         chord_load_q <= '0;
         step_idx_q   <= '0;
         bar_start_q  <= 1'b0;
         step_tick_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         key_q        <= key;
         pending_q    <= pending_d;
         chord_load_q <= chord_load_d;
         step_idx_q   <= step_idx_d;
         bar_start_q  <= bar_start_d;
         step_tick_q  <= tick;
      end
   end

   assign step_tick  = step_tick_q;
   assign step_idx   = step_idx_q;
   assign bar_start  = bar_start_q;
   assign chord_load = chord_load_q;

endmodule

// File: tb/tb_chord_loop_sequencer.sv
// Self-checking bench for chord_loop_sequencer at CLK_HZ=10 (PERIOD=600); chord loads go through a scoreboard queue.
module tb_chord_loop_sequencer;
   localparam int CLK_HZ = 10;
   localparam int NC     = 4;
   localparam int STEPS  = 4;
   localparam int BPM_W  = 8;
   localparam int ACC_W  = 32;

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic             loop_en = 1'b0;
   logic [BPM_W-1:0] bpm = '0;
   logic [NC-1:0]    key = '0;
   logic             step_tick;
   logic [1:0]       step_idx;
   logic             bar_start;
   logic [NC-1:0]    chord_load;
   logic             track_load;
   logic             running;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      int         at;
      logic [3:0] val;
   } load_t;
   load_t exp_q[$];

   chord_loop_sequencer #(
      .CLK_HZ     (CLK_HZ),
      .NUM_CHORDS (NC),
      .STEPS      (STEPS),
      .BPM_W      (BPM_W),
      .ACC_W      (ACC_W)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .loop_en    (loop_en),
      .bpm        (bpm),
      .key        (key),
      .step_tick  (step_tick),
      .step_idx   (step_idx),
      .bar_start  (bar_start),
      .chord_load (chord_load),
      .track_load (track_load),
      .running    (running)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0; loop_en = 1'b0; bpm = '0; key = '0;
      #3;
      checks++;
      if ({step_tick, step_idx, bar_start, chord_load, track_load, running} !== 10'b0) begin
         errors++;
         $display("FAIL reset_outputs got=%b want=%b",
                  {step_tick, step_idx, bar_start, chord_load, track_load, running}, 10'b0);
      end
      repeat (2) next_cycle();
      resetn = 1'b1;
      repeat (3) next_cycle();
      checks++;
      if ({step_tick, step_idx, bar_start, chord_load, track_load, running} !== 10'b0) begin
         errors++;
         $display("FAIL idle_outputs got=%b want=%b",
                  {step_tick, step_idx, bar_start, chord_load, track_load, running}, 10'b0);
      end
      $display("txn reset done cyc=%0d", cyc);
   endtask

   task automatic test_tempo();
      int   c0, n_track, track_at, n_ticks, last_tick, exp_idx, got_gap, want_gap;
      logic want_bar;
      bpm = 8'd120; loop_en = 1'b1; c0 = cyc;
      n_track = 0; track_at = -1; n_ticks = 0; last_tick = -1; exp_idx = 0;
      for (int i = 0; i < 30; i++) begin
         next_cycle();
         if (track_load) begin n_track++; track_at = cyc - c0; end
         if (cyc - c0 == 1) begin
            checks++;
            if (running !== 1'b0) begin errors++; $display("FAIL arm_running got=%b want=0", running); end
         end
         if (cyc - c0 == 2) begin
            checks++;
            if (running !== 1'b1) begin errors++; $display("FAIL run_running got=%b want=1", running); end
         end
         if (step_tick === 1'b1) begin
            n_ticks++;
            got_gap  = (last_tick < 0) ? cyc - c0 : cyc - last_tick;
            want_gap = (last_tick < 0) ? 7 : 5;
            checks++;
            if (got_gap != want_gap) begin
               errors++; $display("FAIL tick_gap_120 got=%0d want=%0d", got_gap, want_gap);
            end
            last_tick = cyc;
            exp_idx = (exp_idx + 1) % STEPS;
            $display("txn tick cyc=%0d step_idx=%0d bar_start=%b", cyc, step_idx, bar_start);
         end
         want_bar = (step_tick === 1'b1) && (exp_idx == 0);
         checks++;
         if (step_idx !== 2'(exp_idx)) begin
            errors++; $display("FAIL step_idx got=%0d want=%0d cyc=%0d", step_idx, exp_idx, cyc);
         end
         checks++;
         if (bar_start !== want_bar) begin
            errors++; $display("FAIL bar_start got=%b want=%b cyc=%0d", bar_start, want_bar, cyc);
         end
      end
      checks++;
      if (n_track != 1) begin errors++; $display("FAIL track_count got=%0d want=1", n_track); end
      checks++;
      if (track_at != 1) begin errors++; $display("FAIL track_latency got=%0d want=1", track_at); end
      checks++;
      if (n_ticks != 5) begin errors++; $display("FAIL tick_count_120 got=%0d want=5", n_ticks); end
   endtask

   task automatic test_key_burst();
      int    t0;
      bit    found;
      load_t e;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin next_cycle(); found = (step_tick === 1'b1); end
      checks++;
      if (!found) begin errors++; $display("FAIL burst_wait_tick got=none want=tick"); end
      t0 = cyc;
      key = 4'b1011;
      exp_q.push_back(load_t'{t0 + 2, 4'b0001});
      exp_q.push_back(load_t'{t0 + 3, 4'b0010});
      exp_q.push_back(load_t'{t0 + 4, 4'b1000});
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         if (chord_load !== 4'b0000) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL burst_extra_load got=%b@%0d want=none", chord_load, cyc);
            end else begin
               e = exp_q.pop_front();
               $display("txn chord_load cyc=%0d got=%b want=%b@%0d", cyc, chord_load, e.val, e.at);
               if (chord_load !== e.val || cyc != e.at) begin
                  errors++; $display("FAIL burst_load got=%b@%0d want=%b@%0d", chord_load, cyc, e.val, e.at);
               end
            end
         end
         checks++;
         if (step_tick === 1'b1 && chord_load !== 4'b0000) begin
            errors++; $display("FAIL burst_load_on_tick got=%b want=0000", chord_load);
         end
      end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL burst_missing got=%0d left want=0", exp_q.size()); end
      exp_q.delete();
      key = 4'b0000;
   endtask

   task automatic test_tick_defer();
      int    t0;
      bit    found;
      load_t e;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin next_cycle(); found = (step_tick === 1'b1); end
      checks++;
      if (!found) begin errors++; $display("FAIL defer_wait_tick got=none want=tick"); end
      t0 = cyc;
      repeat (3) next_cycle();
      key = 4'b0100;
      exp_q.push_back(load_t'{t0 + 6, 4'b0100});
      for (int i = 0; i < 7; i++) begin
         next_cycle();
         if (cyc == t0 + 5) begin
            checks++;
            if (step_tick !== 1'b1 || chord_load !== 4'b0000) begin
               errors++; $display("FAIL defer_tick_cycle got=tick%b/load%b want=tick1/load0000", step_tick, chord_load);
            end
         end
         if (chord_load !== 4'b0000) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL defer_extra_load got=%b@%0d want=none", chord_load, cyc);
            end else begin
               e = exp_q.pop_front();
               $display("txn chord_load cyc=%0d got=%b want=%b@%0d", cyc, chord_load, e.val, e.at);
               if (chord_load !== e.val || cyc != e.at) begin
                  errors++; $display("FAIL defer_load got=%b@%0d want=%b@%0d", chord_load, cyc, e.val, e.at);
               end
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL defer_missing got=%0d left want=0", exp_q.size()); end
      exp_q.delete();
      key = 4'b0000;
   endtask

   task automatic test_bpm_stall();
      int         t0, d, last, n, got_gap, want_gap;
      bit         found;
      logic [1:0] hold_idx;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin next_cycle(); found = (step_tick === 1'b1); end
      checks++;
      if (!found) begin errors++; $display("FAIL stall_wait_tick got=none want=tick"); end
      t0 = cyc;
      // Two cycles past a tick the accumulator holds 240; bpm=0 must freeze it there.
      repeat (2) next_cycle();
      bpm = 8'd0;
      hold_idx = step_idx;
      for (int i = 0; i < 50; i++) begin
         next_cycle();
         checks++;
         if (step_tick !== 1'b0) begin errors++; $display("FAIL stall_tick got=%b want=0 cyc=%0d", step_tick, cyc); end
         checks++;
         if (step_idx !== hold_idx) begin errors++; $display("FAIL stall_idx got=%0d want=%0d", step_idx, hold_idx); end
      end
      $display("txn bpm_stall held step_idx=%0d from cyc=%0d", hold_idx, t0 + 2);
      bpm = 8'd200; d = cyc; last = -1; n = 0;
      for (int i = 0; i < 12; i++) begin
         next_cycle();
         if (step_tick === 1'b1) begin
            n++;
            got_gap  = (last < 0) ? cyc - d : cyc - last;
            want_gap = (last < 0) ? 2 : 3;
            checks++;
            if (got_gap != want_gap) begin errors++; $display("FAIL tick_gap_200 got=%0d want=%0d", got_gap, want_gap); end
            last = cyc;
            $display("txn tick200 cyc=%0d step_idx=%0d", cyc, step_idx);
         end
      end
      checks++;
      if (n != 4) begin errors++; $display("FAIL tick_count_200 got=%0d want=4", n); end
   endtask

   task automatic test_loop_drop();
      int e, n_track, track_at;
      bit found;
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         next_cycle();
         found = (step_tick === 1'b1) && (step_idx === 2'd2);
      end
      checks++;
      if (!found) begin errors++; $display("FAIL drop_wait_step2 got=none want=tick@2"); end
      key = 4'b0100;
      next_cycle();
      loop_en = 1'b0;
      next_cycle();
      checks++;
      if ({running, step_idx, chord_load, step_tick, track_load} !== 9'b0) begin
         errors++;
         $display("FAIL drop_outputs got=%b want=%b", {running, step_idx, chord_load, step_tick, track_load}, 9'b0);
      end
      for (int i = 0; i < 5; i++) begin
         next_cycle();
         checks++;
         if (chord_load !== 4'b0000 || running !== 1'b0 || step_idx !== 2'd0) begin
            errors++; $display("FAIL drop_idle got=load%b/run%b/idx%0d want=load0000/run0/idx0", chord_load, running, step_idx);
         end
      end
      $display("txn loop_drop idle cyc=%0d", cyc);
      loop_en = 1'b1; e = cyc; n_track = 0; track_at = -1;
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         if (track_load === 1'b1) begin n_track++; track_at = cyc - e; end
         checks++;
         if (chord_load !== 4'b0000) begin errors++; $display("FAIL stale_pending got=%b want=0000", chord_load); end
      end
      checks++;
      if (n_track != 1 || track_at != 1) begin
         errors++; $display("FAIL rearm_track got=%0d@%0d want=1@1", n_track, track_at);
      end
      key = 4'b0000;
   endtask

   task automatic test_async_reset();
      bit found;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin next_cycle(); found = (step_tick === 1'b1); end
      checks++;
      if (!found) begin errors++; $display("FAIL areset_wait_tick got=none want=tick"); end
      #2;
      resetn = 1'b0;
      #1;
      checks++;
      if ({step_tick, step_idx, bar_start, chord_load, track_load, running} !== 10'b0) begin
         errors++;
         $display("FAIL async_reset got=%b want=%b",
                  {step_tick, step_idx, bar_start, chord_load, track_load, running}, 10'b0);
      end
      $display("txn async_reset at t=%0t", $time);
      repeat (2) next_cycle();
      resetn = 1'b1;
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_tempo();
      test_key_burst();
      test_tick_defer();
      test_bpm_stall();
      test_loop_drop();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
